// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    // Divider run state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Smallest legal period in clk cycles; smaller requests are clamped to it.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_phase.sv
// Phase decode: maps phase counter k and period P to the divided clock level
// and the four phase strobes. Purely combinational; the top registers it.
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 10
) (
    input  logic             active,
    input  logic [DIV_W-1:0] k,
    input  logic [DIV_W-1:0] p,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             mid_high_stb,
    output logic             mid_low_stb
);

    logic [DIV_W-1:0] h_len;
    logic [DIV_W-1:0] l_len;

    // Split the period into high (the larger half) and low phases, then decode.
    always_comb begin
        l_len        = p >> 1;
        h_len        = p - l_len;
        clk_out      = active && (k < h_len);
        rise_stb     = active && (k == '0);
        fall_stb     = active && (k == h_len);
        mid_high_stb = active && (k == (h_len >> 1));
        mid_low_stb  = active && (k == (h_len + (l_len >> 1)));
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free ratio changes at period
// boundaries, graceful stop (current period drains) and phase strobes.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 10,
    parameter int DIV_DEFAULT = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             load_ack,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             mid_high_stb,
    output logic             mid_low_stb,
    output logic             busy,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] P_RESET = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] P_MIN   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] K_ONE   = DIV_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] k_q, k_d;
    logic [DIV_W-1:0] p_act_q, p_act_d;
    logic [DIV_W-1:0] p_pend_q, p_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             div_err_d;
    logic [DIV_W-1:0] div_clamped;
    logic             wrap;
    logic             apply;

    logic             clk_out_d;
    logic             rise_d;
    logic             fall_d;
    logic             mid_high_d;
    logic             mid_low_d;
    logic             busy_d;

    // Last cycle of the period currently in progress.
    assign wrap = (k_q == p_act_q - K_ONE);

    // State register: FSM state, phase counter, active and pending ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            p_act_q    <= P_RESET;
            p_pend_q   <= P_RESET;
            pend_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            k_q        <= k_d;
            p_act_q    <= p_act_d;
            p_pend_q   <= p_pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Next-state: FSM transitions and phase counter advance.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                k_d = '0;
                if (en) state_d = RUN;
            end
            RUN, DRAIN: begin
                k_d = wrap ? '0 : k_q + K_ONE;
                if (!en && wrap) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Ratio load: clamp and hold the request, promote it at a period boundary
    // (or straight away when idle), and latch any illegal request as an error.
    always_comb begin
        div_clamped = (div_val < P_MIN) ? P_MIN : div_val;
        apply       = pend_vld_q && ((state_q == IDLE) || wrap);
        p_act_d     = apply ? p_pend_q : p_act_q;
        p_pend_d    = div_load ? div_clamped : p_pend_q;
        pend_vld_d  = div_load | (pend_vld_q & ~apply);
        div_err_d   = div_err | (div_load & (div_val < P_MIN));
        busy_d      = (state_d != IDLE);
    end

    // Output decode is done on next-cycle values so the outputs can be registered.
    clk_div_phase #(
        .DIV_W (DIV_W)
    ) u_phase (
        .active       (state_d != IDLE),
        .k            (k_d),
        .p            (p_act_d),
        .clk_out      (clk_out_d),
        .rise_stb     (rise_d),
        .fall_stb     (fall_d),
        .mid_high_stb (mid_high_d),
        .mid_low_stb  (mid_low_d)
    );

    // Output register: every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ack     <= 1'b0;
            clk_out      <= 1'b0;
            rise_stb     <= 1'b0;
            fall_stb     <= 1'b0;
            mid_high_stb <= 1'b0;
            mid_low_stb  <= 1'b0;
            busy         <= 1'b0;
            div_err      <= 1'b0;
        end else begin
            load_ack     <= apply;
            clk_out      <= clk_out_d;
            rise_stb     <= rise_d;
            fall_stb     <= fall_d;
            mid_high_stb <= mid_high_d;
            mid_low_stb  <= mid_low_d;
            busy         <= busy_d;
            div_err      <= div_err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random
// en/load traffic, compared every cycle against a period/phase model.
module tb_clk_div_prog;

    localparam int DIV_W       = 10;
    localparam int DIV_DEFAULT = 30;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             load_ack;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic             mid_high_stb;
    logic             mid_low_stb;
    logic             busy;
    logic             div_err;

    int total = 0;
    int bad   = 0;

    // Reference model: running flag, draining flag, phase, periods.
    bit m_on;
    bit m_stopping;
    int m_k;
    int m_p;
    int m_pend;
    bit m_pend_v;
    bit m_err;
    bit m_ack;

    clk_div_prog #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_val      (div_val),
        .div_load     (div_load),
        .load_ack     (load_ack),
        .clk_out      (clk_out),
        .rise_stb     (rise_stb),
        .fall_stb     (fall_stb),
        .mid_high_stb (mid_high_stb),
        .mid_low_stb  (mid_low_stb),
        .busy         (busy),
        .div_err      (div_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b (t=%0t k=%0d P=%0d)",
                   tag, obs, exp, $time, m_k, m_p);
        end
    endtask

    function automatic void model_reset();
        m_on       = 1'b0;
        m_stopping = 1'b0;
        m_k        = 0;
        m_p        = DIV_DEFAULT;
        m_pend     = DIV_DEFAULT;
        m_pend_v   = 1'b0;
        m_err      = 1'b0;
        m_ack      = 1'b0;
    endfunction

    // One clk edge of the specified behaviour, using inputs held across the edge.
    function automatic void model_step();
        bit end_of_period;
        bit take_new;
        end_of_period = m_on && (m_k == m_p - 1);
        take_new      = m_pend_v && (!m_on || end_of_period);
        if (!m_on) begin
            m_k = 0;
            if (en) m_on = 1'b1;
        end else begin
            m_k = end_of_period ? 0 : m_k + 1;
            if (!en && end_of_period) begin
                m_on = 1'b0;
                m_k  = 0;
            end
            m_stopping = !en && m_on;
        end
        m_ack = take_new;
        if (take_new) begin
            m_p      = m_pend;
            m_pend_v = 1'b0;
        end
        if (div_load) begin
            m_pend   = (int'(div_val) < 2) ? 2 : int'(div_val);
            m_pend_v = 1'b1;
            if (int'(div_val) < 2) m_err = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        int  h;
        int  l;
        h = m_p - m_p / 2;
        l = m_p / 2;
        check("clk_out",      clk_out,      m_on && (m_k < h));
        check("rise_stb",     rise_stb,     m_on && (m_k == 0));
        check("fall_stb",     fall_stb,     m_on && (m_k == h));
        check("mid_high_stb", mid_high_stb, m_on && (m_k == h / 2));
        check("mid_low_stb",  mid_low_stb,  m_on && (m_k == h + l / 2));
        check("busy",         busy,         m_on);
        check("load_ack",     load_ack,     m_ack);
        check("div_err",      div_err,      m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model sits at phase k=target while running (bounded).
    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (!(m_on && m_k == target) && n < 500) begin
            cycle();
            n++;
        end
        check("wait_k_reached", busy, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_on && n < 500) begin
            cycle();
            n++;
        end
        check("wait_idle_reached", busy, 1'b0);
    endtask

    task automatic load(input int v);
        div_load = 1'b1;
        div_val  = DIV_W'(v);
        cycle();
        div_load = 1'b0;
    endtask

    initial begin
        // Reset state.
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // Default period of 30 free-running.
        en = 1'b1;
        run(70);

        // Ratio change mid-period: old period completes, then 10-cycle periods.
        wait_k(12);
        load(10);
        run(45);

        // P=5 and P=2 shapes.
        load(5);
        run(25);
        load(2);
        run(12);

        // Illegal ratios clamp to 2 and set the sticky error.
        load(1);
        run(8);
        load(0);
        run(8);

        // Back to 30; two loads before the boundary, only the last applies.
        load(30);
        wait_k(3);
        load(7);
        load(9);
        run(40);
        load(30);
        run(40);

        // en drop at k=5: period drains to k=29 then idle.
        wait_k(5);
        en = 1'b0;
        wait_idle();
        run(5);

        // en drop then reassert during drain: period continues unbroken.
        en = 1'b1;
        wait_k(5);
        en = 1'b0;
        wait_k(20);
        en = 1'b1;
        run(45);

        // Load lands on the same boundary as an en-drop completion.
        wait_k(27);
        load(12);
        cycle();
        en = 1'b0;
        cycle();
        run(4);

        // Load while idle takes effect without running.
        load(6);
        run(3);
        en = 1'b1;
        run(20);
        load(30);
        run(35);

        // Asynchronous reset mid-period.
        wait_k(9);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        run(70);

        // Random en / load traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(19) == 0) en = ~en;
            if ($urandom_range(39) == 0) begin
                div_load = 1'b1;
                div_val  = DIV_W'($urandom_range(0, 14));
            end else begin
                div_load = 1'b0;
            end
            cycle();
        end
        div_load = 1'b0;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter DIV_W, default 10, meaning the width of the divide-ratio field.
REQ-002 The block SHALL have parameter DIV_DEFAULT, default 30, meaning the period P in clk cycles loaded at reset.
REQ-003 Port clk, input, 1 bit: clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port en, input, 1 bit: run request.
REQ-006 Port div_val, input, DIV_W bits: requested period P in clk cycles.
REQ-007 Port div_load, input, 1 bit: single-cycle strobe that captures div_val.
REQ-008 Port load_ack, output, 1 bit: single-cycle strobe when the captured ratio takes effect.
REQ-009 Port clk_out, output, 1 bit: divided clock.
REQ-010 Port rise_stb, output, 1 bit: strobe on the first high cycle of clk_out.
REQ-011 Port fall_stb, output, 1 bit: strobe on the first low cycle of clk_out.
REQ-012 Port mid_high_stb, output, 1 bit: strobe at the centre of the high phase.
REQ-013 Port mid_low_stb, output, 1 bit: strobe at the centre of the low phase.
REQ-014 Port busy, output, 1 bit: high in states RUN and DRAIN.
REQ-015 Port div_err, output, 1 bit: sticky flag for an illegal ratio.

Function
REQ-016 Active period P SHALL have high phase H = P - (P>>1) and low phase L = P>>1; phase counter k runs 0..P-1, then wraps to 0.
REQ-017 All outputs SHALL be registered; in a cycle with phase k in RUN/DRAIN, clk_out = (k < H).
REQ-018 Strobe positions: rise_stb at k=0; fall_stb at k=H; mid_high_stb at k=H>>1; mid_low_stb at k=H+(L>>1); coincident strobes all assert.
REQ-019 State machine IDLE->RUN: en sampled 1 in IDLE; the first cycle with k=0 is the next cycle.
REQ-020 State machine RUN->DRAIN: en sampled 0; the current period completes.
REQ-021 State machine DRAIN->IDLE: on the cycle after k=P-1.
REQ-022 State machine DRAIN->RUN: en sampled 1 again; the period continues without a glitch.
REQ-023 In IDLE, clk_out and all strobes SHALL be 0 and k SHALL be 0.
REQ-024 div_load SHALL capture div_val into a pending register; the pending ratio becomes active at the next k=0 boundary, or on the next cycle if IDLE.
REQ-025 load_ack SHALL pulse in the first cycle the new P applies.
REQ-026 A second div_load before the boundary SHALL overwrite the pending value; only one load_ack is issued.
REQ-027 div_val < 2 SHALL be clamped to 2 and SHALL set div_err; div_err clears only on reset.
REQ-028 A load landing at the same boundary as an en-drop completion SHALL still apply, with load_ack issued in IDLE.
REQ-029 Counter arithmetic SHALL be DIV_W bits unsigned with no overflow; P maximum is 2^DIV_W-1.

Reset
REQ-030 On rst_n low, the block SHALL force IDLE, k=0, active P = pending P = DIV_DEFAULT, all outputs 0, and div_err=0, regardless of the operation in progress.
REQ-031 Release SHALL be synchronised externally; the block SHALL resume in IDLE and respond to en from the first clock after release.

Structure
REQ-032 Shared package clk_div_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and the constant MIN_DIV=2.
REQ-033 One sub-module, clk_div_phase (phase decode of k,P to clk_out and strobes), is natural; the FSM, counter and load logic stay in the top.

Verification
REQ-034 P=30, en=1: clk_out 15 high/15 low repeating; mid_high at k=7, mid_low at k=22; rise_stb every 30 cycles.
REQ-035 P=5: high 3, low 2; mid_high k=1, fall k=3, mid_low k=4; P=2: all four strobes alternate each cycle.
REQ-036 Running P=30, div_load 10 at k=12: old period ends; load_ack with next rise_stb; subsequent periods are 10 cycles.
REQ-037 div_val=1 loaded: div_err=1, period becomes 2; div_val=0 likewise.
REQ-038 en dropped at k=5 (P=30): busy stays high through k=29, then IDLE with clk_out=0; en reasserted at k=20 continues without a restart.
REQ-039 rst_n asserted at k=9: next edge has all outputs 0 and busy=0; after release, P=30 without any load.
